fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register: the producer side of the `instruction` / `PCNEXT_init` interface that `decode_stage` consumes. It owns the PC and runs a single-outstanding request/response handshake with the instruction cache. It handles branch redirects and stalls, including responses still in flight. It drives `block_pipe_instr_cache` to the control unit while no instruction is available.

---
 rtl/pipeline_pkg.sv | 25 ++
 rtl/fetch_stage_if.sv | 33 +++
 rtl/fetch_hold_buf.sv | 32 +++
 rtl/fetch_stage.sv | 138 +++++++++++++
 tb/tb_fetch_stage.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg : shared fetch/decode types and constants.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipeline_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4
    } fetch_state_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if : instruction-cache request/response bus.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fetch_stage_if;
    import pipeline_pkg::*;

    logic               icache_req_valid;
    logic [31:0]        icache_req_addr;
    logic               icache_req_ready;
    logic               icache_resp_valid;
    logic [INSTR_W-1:0] icache_resp_data;

    modport master (
        output icache_req_valid,
        output icache_req_addr,
        input  icache_req_ready,
        input  icache_resp_valid,
        input  icache_resp_data
    );

    modport slave (
        input  icache_req_valid,
        input  icache_req_addr,
        output icache_req_ready,
        output icache_resp_valid,
        output icache_resp_data
    );

endinterface

`default_nettype wire

// File: rtl/fetch_hold_buf.sv
// ---------------------------------------------------------------------------
// fetch_hold_buf : one-entry word buffer for responses arriving during a stall.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_hold_buf
    import pipeline_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               load,
    input  wire logic               clear,
    input  wire logic [INSTR_W-1:0] din,
    output logic      [INSTR_W-1:0] data,
    output logic                    valid
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data  <= NOP_INSTR;
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            data  <= din;
            valid <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage : PC, single-outstanding I-cache fetch FSM and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds cycle/stall counters.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               EN_REG,
    input  wire logic               flush,
    input  wire logic               branch_taken,
    input  wire logic [31:0]        branch_target,
    fetch_stage_if.master           icache,
    output logic      [INSTR_W-1:0] instruction,
    output logic      [31:0]        PCNEXT,
    output logic                    valid,
    output logic                    block_pipe_instr_cache
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic      [31:0]        perf_fetch_cycles,
    output logic      [31:0]        perf_fetch_stall
`endif
);

    fetch_state_t       r_state;
    logic [31:0]        r_pc;
    logic [INSTR_W-1:0] w_buf_data;
    logic               w_buf_valid;

    logic               w_resp;
    logic               w_hold;
    logic               w_deliverable;
    logic               w_advance;
    logic               w_capture;
    logic               w_buf_clear;
    logic [INSTR_W-1:0] w_word;
    logic [31:0]        w_pc_inc;
    logic [31:0]        w_target;

    assign w_resp        = (r_state == S_WAIT) && icache.icache_resp_valid;
    assign w_hold        = (r_state == S_HOLD) && w_buf_valid;
    assign w_deliverable = w_resp || w_hold;
    assign w_advance     = w_deliverable && EN_REG && !flush && !branch_taken;
    // A flushed or stalled response is parked, never lost; pc stays on it.
    assign w_capture     = w_resp && !w_advance && !branch_taken;
    assign w_buf_clear   = (r_state == S_HOLD) && (w_advance || branch_taken);
    assign w_word        = w_hold ? w_buf_data : icache.icache_resp_data;
    assign w_pc_inc      = pc_plus4(r_pc);
    assign w_target      = branch_target & 32'hFFFF_FFFC;

    assign icache.icache_req_valid = (r_state == S_REQ) || (w_resp && w_advance);
    assign icache.icache_req_addr  = (r_state == S_WAIT) ? w_pc_inc : r_pc;
    assign block_pipe_instr_cache  = !w_deliverable;

    fetch_hold_buf u_hold_buf (
        .clk   (clk),
        .reset (reset),
        .load  (w_capture),
        .clear (w_buf_clear),
        .din   (icache.icache_resp_data),
        .data  (w_buf_data),
        .valid (w_buf_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            instruction <= NOP_INSTR;
            PCNEXT      <= '0;
            valid       <= 1'b0;
        end else begin
            if (branch_taken || flush || (EN_REG && !w_deliverable)) begin
                instruction <= NOP_INSTR;
                valid       <= 1'b0;
            end else if (EN_REG) begin
                instruction <= w_word;
                PCNEXT      <= w_pc_inc;
                valid       <= 1'b1;
            end

            if (branch_taken) begin
                r_pc <= w_target;
                case (r_state)
                    S_REQ:   r_state <= icache.icache_req_ready  ? S_DROP : S_REQ;
                    S_WAIT:  r_state <= icache.icache_resp_valid ? S_REQ  : S_DROP;
                    S_DROP:  r_state <= icache.icache_resp_valid ? S_REQ  : S_DROP;
                    default: r_state <= S_REQ;
                endcase
            end else begin
                if (w_advance) begin
                    r_pc <= w_pc_inc;
                end
                case (r_state)
                    S_IDLE: r_state <= S_REQ;
                    S_REQ: begin
                        if (icache.icache_req_ready) r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (w_resp) begin
                            if (w_advance) r_state <= icache.icache_req_ready ? S_WAIT : S_REQ;
                            else           r_state <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (w_advance) r_state <= S_REQ;
                    end
                    S_DROP: begin
                        if (icache.icache_resp_valid) r_state <= S_REQ;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_cycles <= '0;
            perf_fetch_stall  <= '0;
        end else begin
            perf_fetch_cycles <= perf_fetch_cycles + 32'd1;
            if (block_pipe_instr_cache && EN_REG) begin
                perf_fetch_stall <= perf_fetch_stall + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage : directed bench for fetch_stage with an I-cache model and
// an in-order scoreboard of delivered instructions.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        EN_REG = 1'b1;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] instruction;
    logic [31:0] PCNEXT;
    logic        valid;
    logic        block_pipe_instr_cache;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cycles;
    logic [31:0] perf_fetch_stall;
`endif

    fetch_stage_if icache_bus();

    int          n_tests = 0;
    int          n_fail = 0;
    int          n_popped = 0;
    logic [63:0] sb[$];
    logic [63:0] exp_w;

    logic        cache_ready = 1'b0;
    int          resp_delay = 1;
    logic        load_seen = 1'b0;

    always #5 clk = ~clk;

    assign icache_bus.icache_req_ready = cache_ready;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .EN_REG                 (EN_REG),
        .flush                  (flush),
        .branch_taken           (branch_taken),
        .branch_target          (branch_target),
        .icache                 (icache_bus),
        .instruction            (instruction),
        .PCNEXT                 (PCNEXT),
        .valid                  (valid),
        .block_pipe_instr_cache (block_pipe_instr_cache)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cycles      (perf_fetch_cycles),
        .perf_fetch_stall       (perf_fetch_stall)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_000A + (a >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pcn);
        sb.push_back({instr, pcn});
    endtask

    // Cache model: samples just before each rising edge, answers accepted
    // requests resp_delay edges later with a one-cycle response pulse.
    initial begin
        logic        s_acc, s_resp, s_load, pend;
        logic [31:0] s_addr, p_addr;
        int          cnt;
        pend = 1'b0;
        p_addr = '0;
        cnt = 0;
        icache_bus.icache_resp_valid = 1'b0;
        icache_bus.icache_resp_data  = '0;
        forever begin
            @(negedge clk);
            #4;
            s_acc  = icache_bus.icache_req_valid && cache_ready;
            s_resp = icache_bus.icache_resp_valid;
            s_addr = icache_bus.icache_req_addr;
            s_load = reset && EN_REG && !flush && !branch_taken;
            @(posedge clk);
            #1;
            load_seen = s_load;
            if (!reset) begin
                pend = 1'b0;
                icache_bus.icache_resp_valid = 1'b0;
            end else begin
                if (s_resp) icache_bus.icache_resp_valid = 1'b0;
                if (s_acc) begin
                    pend   = 1'b1;
                    p_addr = s_addr;
                    cnt    = resp_delay;
                end
                if (pend) begin
                    if (cnt <= 1) begin
                        icache_bus.icache_resp_valid = 1'b1;
                        icache_bus.icache_resp_data  = mem_word(p_addr);
                        pend = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset && load_seen && valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL sb_unexpected: got instr %h, expected none", instruction);
            end else begin
                exp_w = sb.pop_front();
                chk("sb_instr", instruction, exp_w[63:32]);
                chk("sb_pcnext", PCNEXT, exp_w[31:0]);
                n_popped++;
            end
        end
    end

    initial begin
        // reset values
        step(2);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_pcnext", PCNEXT, 32'h0);
        chk("rst_valid", {31'b0, valid}, 32'h0);
        chk("rst_req_valid", {31'b0, icache_bus.icache_req_valid}, 32'h0);
        chk("rst_req_addr", icache_bus.icache_req_addr, 32'h0);
        chk("rst_block", {31'b0, block_pipe_instr_cache}, 32'h1);
        reset = 1'b1;

        // streaming fetch of 0xA/0xB/0xC
        step();
        chk("first_req_valid", {31'b0, icache_bus.icache_req_valid}, 32'h1);
        chk("first_req_addr", icache_bus.icache_req_addr, 32'h0);
        cache_ready = 1'b1;
        push(32'hA, 32'h4);
        push(32'hB, 32'h8);
        push(32'hC, 32'hC);
        step(3);
        cache_ready = 1'b0;
        step();
        chk("stream_count", n_popped, 32'd3);

        // response during a three-cycle stall
        EN_REG = 1'b0;
        cache_ready = 1'b1;
        push(32'hD, 32'h10);
        step();
        cache_ready = 1'b0;
        chk("stall_resp_block", {31'b0, block_pipe_instr_cache}, 32'h0);
        chk("stall_no_req", {31'b0, icache_bus.icache_req_valid}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_instr", instruction, 32'hC);
            chk("stall_pcnext", PCNEXT, 32'hC);
            chk("stall_valid", {31'b0, valid}, 32'h1);
            chk("hold_block", {31'b0, block_pipe_instr_cache}, 32'h0);
        end
        EN_REG = 1'b1;
        step();
        chk("hold_count", n_popped, 32'd4);
        chk("hold_next_addr", icache_bus.icache_req_addr, 32'h10);
        step();
        chk("hold_no_dup", {31'b0, valid}, 32'h0);

        // redirect while waiting for a slow response
        cache_ready = 1'b1;
        resp_delay = 3;
        step();
        cache_ready = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'h0000_0102;
        step();
        branch_taken = 1'b0;
        chk("br_wait_valid", {31'b0, valid}, 32'h0);
        chk("br_wait_pcnext", PCNEXT, 32'h10);
        chk("br_drop_no_req", {31'b0, icache_bus.icache_req_valid}, 32'h0);
        chk("br_drop_block", {31'b0, block_pipe_instr_cache}, 32'h1);
        cache_ready = 1'b1;
        resp_delay = 1;
        push(mem_word(32'h100), 32'h104);
        step();
        chk("br_drop_wait", {31'b0, icache_bus.icache_req_valid}, 32'h0);
        step();
        chk("br_tgt_req_valid", {31'b0, icache_bus.icache_req_valid}, 32'h1);
        chk("br_tgt_req_addr", icache_bus.icache_req_addr, 32'h100);
        step();
        cache_ready = 1'b0;
        step();
        chk("br_count", n_popped, 32'd5);

        // redirect in the same cycle as the response
        EN_REG = 1'b0;
        cache_ready = 1'b1;
        step();
        cache_ready = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'h0000_0200;
        chk("brr_resp_block", {31'b0, block_pipe_instr_cache}, 32'h0);
        step();
        branch_taken = 1'b0;
        chk("brr_valid", {31'b0, valid}, 32'h0);
        chk("brr_instr", instruction, 32'h0);
        chk("brr_pcnext", PCNEXT, 32'h104);
        chk("brr_req_valid", {31'b0, icache_bus.icache_req_valid}, 32'h1);
        chk("brr_req_addr", icache_bus.icache_req_addr, 32'h200);
        EN_REG = 1'b1;
        cache_ready = 1'b1;
        push(mem_word(32'h200), 32'h204);
        step();
        cache_ready = 1'b0;
        step();
        chk("brr_count", n_popped, 32'd6);

        // PC wrap at the top of the address space
        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFF;
        step();
        branch_taken = 1'b0;
        chk("wrap_valid", {31'b0, valid}, 32'h0);
        chk("wrap_req_valid", {31'b0, icache_bus.icache_req_valid}, 32'h1);
        chk("wrap_req_addr", icache_bus.icache_req_addr, 32'hFFFF_FFFC);
        cache_ready = 1'b1;
        push(mem_word(32'hFFFF_FFFC), 32'h0);
        step();
        cache_ready = 1'b0;
        step();
        chk("wrap_count", n_popped, 32'd7);
        chk("wrap_next_addr", icache_bus.icache_req_addr, 32'h0);

        // flush while a word sits in the hold buffer
        EN_REG = 1'b0;
        cache_ready = 1'b1;
        step();
        cache_ready = 1'b0;
        step();
        chk("fl_pre_valid", {31'b0, valid}, 32'h1);
        chk("fl_pre_block", {31'b0, block_pipe_instr_cache}, 32'h0);
        flush = 1'b1;
        EN_REG = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_valid", {31'b0, valid}, 32'h0);
        chk("fl_instr", instruction, 32'h0);
        chk("fl_buf_kept", {31'b0, block_pipe_instr_cache}, 32'h0);
        push(32'hA, 32'h4);
        step();
        chk("fl_count", n_popped, 32'd8);
        chk("fl_next_addr", icache_bus.icache_req_addr, 32'h4);

        // asynchronous reset in the middle of a wait
        EN_REG = 1'b0;
        cache_ready = 1'b1;
        resp_delay = 3;
        step();
        cache_ready = 1'b0;
        chk("ar_pre_valid", {31'b0, valid}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_instr", instruction, 32'h0);
        chk("ar_pcnext", PCNEXT, 32'h0);
        chk("ar_valid", {31'b0, valid}, 32'h0);
        chk("ar_req_valid", {31'b0, icache_bus.icache_req_valid}, 32'h0);
        chk("ar_req_addr", icache_bus.icache_req_addr, 32'h0);
        chk("ar_block", {31'b0, block_pipe_instr_cache}, 32'h1);
        step();
        reset = 1'b1;
        EN_REG = 1'b1;
        cache_ready = 1'b1;
        resp_delay = 1;
        step();
        chk("ar_refetch_valid", {31'b0, icache_bus.icache_req_valid}, 32'h1);
        chk("ar_refetch_addr", icache_bus.icache_req_addr, 32'h0);
        push(32'hA, 32'h4);
        step();
        cache_ready = 1'b0;
        step();
        chk("ar_count", n_popped, 32'd9);
        chk("sb_left", sb.size(), 32'd0);

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
